// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder and its write buffer.
package dmem_pkg;
    localparam int AW         = 7;
    localparam int DW         = 32;
    localparam int DEPTH      = 1 << AW;
    localparam int WBUF_DEPTH = 4;
    localparam int PTR_W      = $clog2(WBUF_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef logic [PTR_W-1:0] wptr_t;
    typedef logic [CNT_W-1:0] wcnt_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbuf_entry_t;
endpackage

// File: rtl/dmem_wbuf.sv
// Coalescing posted-write FIFO: address lookup for forwarding/coalesce,
// enqueue at tail, drain one head entry per cycle.
module dmem_wbuf
    import dmem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          idle,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic          hit,
    output logic [DW-1:0] hit_data,
    output logic          drain,
    output logic [AW-1:0] drain_addr,
    output logic [DW-1:0] drain_data,
    output wcnt_t         cnt
);
    wbuf_entry_t ent [WBUF_DEPTH];
    wptr_t       head, tail, hit_idx;
    logic        full, coalesce, enq;

    // At most one live entry per address, so the last match is the only match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (ent[i].valid && ent[i].addr == addr) begin
                hit     = 1'b1;
                hit_idx = wptr_t'(i);
            end
        end
    end

    assign hit_data   = ent[hit_idx].data;
    assign full       = (cnt == wcnt_t'(WBUF_DEPTH));
    assign drain      = (cnt != '0) && (idle || (full && wr_en && !hit));
    // A write hitting the head that is leaving this cycle becomes a fresh entry.
    assign coalesce   = wr_en && hit && !(drain && hit_idx == head);
    assign enq        = wr_en && !coalesce;
    assign drain_addr = ent[head].addr;
    assign drain_data = ent[head].data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WBUF_DEPTH; i++) ent[i] <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (drain) begin
                ent[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            if (coalesce) ent[hit_idx].data <= wr_data;
            // When full, tail == head: the enqueue overrides the head invalidate.
            if (enq) begin
                ent[tail] <= '{valid: 1'b1, addr: addr, data: wr_data};
                tail      <= tail + 1'b1;
            end
            cnt <= cnt + wcnt_t'(enq) - wcnt_t'(drain);
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Zero-latency data-memory responder for active-low CEN/WEN/OEN strobes.
// Define DMEM_WBUF_EN to post writes through the coalescing write buffer.
module dmem_responder
    import dmem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        CEN,
    input  logic                        WEN,
    input  logic                        OEN,
    input  logic [AW-1:0]               A,
    input  logic [DW-1:0]               Data2Mem,
    output logic [DW-1:0]               ReadDataMem,
    output logic                        wbuf_empty,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_cnt
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q, rd_val;
    logic          wr_acc, rd_acc;

    assign wr_acc = !CEN && !WEN;
    assign rd_acc = !CEN && WEN && !OEN;

`ifdef DMEM_WBUF_EN
    logic          hit, drain;
    logic [DW-1:0] hit_data, drain_data;
    logic [AW-1:0] drain_addr;
    wcnt_t         cnt;

    dmem_wbuf u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_acc),
        .idle       (CEN),
        .addr       (A),
        .wr_data    (Data2Mem),
        .hit        (hit),
        .hit_data   (hit_data),
        .drain      (drain),
        .drain_addr (drain_addr),
        .drain_data (drain_data),
        .cnt        (cnt)
    );

    assign rd_val     = hit ? hit_data : mem[A];
    assign wbuf_cnt   = cnt;
    assign wbuf_empty = (cnt == '0);

    always_ff @(posedge clk) begin
        if (drain) mem[drain_addr] <= drain_data;
    end
`else
    assign rd_val     = mem[A];
    assign wbuf_cnt   = '0;
    assign wbuf_empty = 1'b1;

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[A] <= Data2Mem;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata_q <= '0;
        else if (rd_acc) rdata_q <= rd_val;
    end

    assign ReadDataMem = rd_acc ? rd_val : rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected read data is queued at drive time
// and popped when the read output is sampled; status checks follow the build.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_WBUF_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        CEN, WEN, OEN;
    logic [AW-1:0]               A;
    logic [DW-1:0]               Data2Mem;
    logic [DW-1:0]               ReadDataMem;
    logic                        wbuf_empty;
    logic [$clog2(WBUF_DEPTH):0] wbuf_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   sb [$];

    dmem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .wbuf_empty  (wbuf_empty),
        .wbuf_cnt    (wbuf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Status reflects all posedges before the current cycle.
    task automatic chk_st(input string tag, input int n);
        chk({tag, "_cnt"}, 32'(wbuf_cnt), WB ? 32'(n) : 32'd0);
        chk({tag, "_empty"}, 32'(wbuf_empty), (WB && n != 0) ? 32'd0 : 32'd1);
    endtask

    task automatic drive(input logic c, input logic w, input logic o,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        CEN = c; WEN = w; OEN = o; A = a; Data2Mem = d;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b0, 1'b0, 1'b1, a, d);
        #1;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(1'b0, 1'b1, 1'b0, a, '0);
        sb.push_back(exp);
        #1;
        chk(tag, ReadDataMem, sb.pop_front());
    endtask

    task automatic nop(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(1'b0, 1'b1, 1'b1, a, '0);
        sb.push_back(exp);
        #1;
        chk(tag, ReadDataMem, sb.pop_front());
    endtask

    initial begin
        rst_n = 1'b0;
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", ReadDataMem, 32'h0);
        chk("rst_cnt", 32'(wbuf_cnt), 32'h0);
        chk("rst_empty", 32'(wbuf_empty), 32'h1);
        rst_n = 1'b1;

        // write, forward, drain
        wr(5, 32'hDEADBEEF);
        rd("fwd5", 5, 32'hDEADBEEF);
        chk_st("fwd5", 1);
        idle();
        rd("arr5", 5, 32'hDEADBEEF);
        chk_st("arr5", 0);

        // coalesce
        wr(3, 32'h1);
        wr(3, 32'h2);
        rd("coal3", 3, 32'h2);
        chk_st("coal3", 1);
        idle();
        rd("coal3_arr", 3, 32'h2);
        chk_st("coal3_arr", 0);

        // full buffer with forced drain
        for (int i = 0; i < 5; i++) begin
            wr(AW'(i), 32'h10 + 32'(i));
            if (i == 4) chk_st("full4", 4);
        end
        for (int i = 0; i < 5; i++) begin
            rd($sformatf("full_rd%0d", i), AW'(i), 32'h10 + 32'(i));
            if (i == 0) chk_st("full5", 4);
        end
        repeat (4) idle();
        for (int i = 0; i < 5; i++) begin
            rd($sformatf("drained_rd%0d", i), AW'(i), 32'h10 + 32'(i));
            if (i == 0) chk_st("drained", 0);
        end

        // reset mid-operation discards the posted write
        wr(7, 32'hAA);
        idle();
        chk_st("pre_drain7", 1);
        wr(7, 32'hBB);
        chk_st("post_drain7", 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_st("midrst", 0);
        chk("midrst_rdata", ReadDataMem, 32'h0);
        rst_n = 1'b1;
        rd("rst7", 7, WB ? 32'hAA : 32'hBB);

        // OEN gating: hold last read data, no drain
        wr(20, 32'h55);
        rd("oen_rd5", 5, 32'hDEADBEEF);
        chk_st("oen_pend", 1);
        nop("oen_hold", 9, 32'hDEADBEEF);
        nop("oen_hold2", 9, 32'hDEADBEEF);
        chk_st("oen_nodrain", 1);
        idle();
        rd("oen_rd20", 20, 32'h55);
        chk_st("oen_drained", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
